cpu_program_sequencer: RTL and testbench

- Upstream instruction feeder for the 4-bit accumulator CPU core.
- Buffers a short program of 12-bit instruction words, loaded over a valid/ready handshake.
- On start, issues the words in order as {opcode, data, addr, write-enable}, each held long enough for the CPU's two-state FSM to execute it.
- Drives a NOP opcode (4'b1111) whenever no instruction is issued, so the CPU stays in IDLE.

---
 rtl/cpu_program_sequencer_if.sv | 24 ++
 rtl/cpu_program_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_program_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_program_sequencer_if.sv
// Bus bundle between the program sequencer and its neighbours: the
// valid/ready load channel feeding instruction words in, and the
// instruction bus driven toward the accumulator CPU core.
interface cpu_program_sequencer_if;
  logic        load_valid;
  logic        load_ready;
  logic [11:0] load_word;
  logic [3:0]  cpu_opcode;
  logic [3:0]  cpu_data;
  logic [3:0]  cpu_addr;
  logic        cpu_we;

  // Producer of load words / consumer of the CPU instruction bus.
  modport master (
    output load_valid, load_word,
    input  load_ready, cpu_opcode, cpu_data, cpu_addr, cpu_we
  );

  // The sequencer itself.
  modport slave (
    input  load_valid, load_word,
    output load_ready, cpu_opcode, cpu_data, cpu_addr, cpu_we
  );
endinterface

// File: rtl/cpu_program_sequencer.sv
// Program sequencer for the 4-bit accumulator CPU core.
// Buffers up to DEPTH 12-bit instruction words ({opcode,data,addr}) and,
// on start, issues them in order, holding each for HOLD cycles followed by
// one NOP gap cycle. A HALT opcode (4'hF) or the end of the program ends
// the run in DONE.
// Optional feature macro: CPU_SEQ_LOOP_EN -- when defined, end of program
// or HALT wraps back to slot 0 and the run continues until stop.
module cpu_program_sequencer #(
  parameter int DEPTH = 16,
  parameter int HOLD  = 3,
  parameter int PC_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_program_sequencer_if.slave bus,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  output logic                   issue_strobe,
  output logic [PC_W-1:0]        pc,
  output logic [PC_W:0]          prog_len,
  output logic                   busy,
  output logic                   done
);
  localparam int         CNT_W    = $clog2(HOLD);
  localparam logic [3:0] OP_NOP   = 4'hF;
  localparam logic [3:0] OP_STORE = 4'h2;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W:0]     len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d, data_q, data_d, addr_q, addr_d;
  logic              we_q, we_d, strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;

  logic [11:0]       mem_q [DEPTH];

  logic              load_ready_w, load_fire;
  logic [PC_W:0]     pc_inc;
  logic [PC_W-1:0]   fetch_pc, issue_pc;
  logic              fetch_end, fetch_halt, do_fetch, go_idle, issue_en;
  logic [11:0]       fetch_word, issue_word;

  // Load handshake: only accept words while not running and not full.
  always_comb begin
    load_ready_w = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                   (len_q < (PC_W+1)'(DEPTH));
    load_fire    = bus.load_valid && load_ready_w;
  end

  // Program buffer; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (load_fire) mem_q[len_q[PC_W-1:0]] <= bus.load_word;
  end

  // Fetch address/word: slot 0 on start, pc+1 out of GAP. A word being
  // loaded in the start cycle is forwarded so it can be issued at once.
  always_comb begin
    pc_inc = {1'b0, pc_q} + (PC_W+1)'(1);
    if (state_q == ST_GAP) begin
      fetch_pc  = pc_inc[PC_W-1:0];
      fetch_end = (pc_inc == len_q);
    end else begin
      fetch_pc  = '0;
      fetch_end = 1'b0;
    end
    fetch_word = (load_fire && (fetch_pc == len_q[PC_W-1:0])) ? bus.load_word
                                                              : mem_q[fetch_pc];
    fetch_halt = (fetch_word[11:8] == OP_NOP);
  end

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    data_d     = data_q;
    addr_d     = addr_q;
    we_d       = we_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    do_fetch   = 1'b0;
    go_idle    = 1'b0;
    issue_en   = 1'b0;
    issue_pc   = fetch_pc;
    issue_word = fetch_word;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (clear) begin
          state_d = ST_IDLE;
          pc_d    = '0;
          len_d   = '0;
          done_d  = 1'b0;
        end else begin
          if (load_fire) begin
            len_d   = len_q + (PC_W+1)'(1);
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end
          if (start && !stop && (len_d != '0)) do_fetch = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (cnt_q == CNT_W'(HOLD-1)) begin
          state_d = ST_GAP;
          op_d    = OP_NOP;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (stop) go_idle = 1'b1;
        else      do_fetch = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (do_fetch) begin
      if (!(fetch_end || fetch_halt)) begin
        issue_en = 1'b1;
      end else begin
`ifdef CPU_SEQ_LOOP_EN
        // Wrap to slot 0; a HALT there leaves nothing runnable, so park.
        pc_d = '0;
        if (mem_q[0][11:8] != OP_NOP) begin
          issue_en   = 1'b1;
          issue_pc   = '0;
          issue_word = mem_q[0];
        end else begin
          go_idle = 1'b1;
        end
`else
        state_d = ST_DONE;
        pc_d    = fetch_pc;
        op_d    = OP_NOP;
        data_d  = '0;
        addr_d  = '0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`endif
      end
    end

    if (go_idle) begin
      state_d = ST_IDLE;
      op_d    = OP_NOP;
      data_d  = '0;
      addr_d  = '0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end

    if (issue_en) begin
      state_d  = ST_HOLD;
      pc_d     = issue_pc;
      op_d     = issue_word[11:8];
      data_d   = issue_word[7:4];
      addr_d   = issue_word[3:0];
      we_d     = (issue_word[11:8] == OP_STORE);
      strobe_d = 1'b1;
      cnt_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end
  end

  // State and registered outputs; reset drives the CPU bus to NOP at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      data_q   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.load_ready = load_ready_w;
  assign bus.cpu_opcode = op_q;
  assign bus.cpu_data   = data_q;
  assign bus.cpu_addr   = addr_q;
  assign bus.cpu_we     = we_q;
  assign issue_strobe   = strobe_q;
  assign pc             = pc_q;
  assign prog_len       = len_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Self-checking bench for cpu_program_sequencer: directed scenarios plus
// randomized programs, compared against a program-level reference model
// that derives each cycle's expected bus values from the program list.
module tb_cpu_program_sequencer;
  localparam int DEPTH = 16;
  localparam int HOLD  = 3;
  localparam int PC_W  = 4;
  localparam int PER   = HOLD + 1;
`ifdef CPU_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            clear = 1'b0;
  logic            issue_strobe, busy, done;
  logic [PC_W-1:0] pc;
  logic [PC_W:0]   prog_len;

  cpu_program_sequencer_if bus();

  cpu_program_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .issue_strobe (issue_strobe),
    .pc           (pc),
    .prog_len     (prog_len),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] prog_m[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of instructions a run issues before HALT or end of program.
  function automatic int count_issue();
    int n = 0;
    while (n < prog_m.size() && prog_m[n][11:8] != 4'hF) n++;
    return n;
  endfunction

  function automatic int pick_stop(input int n);
    if (n == 0) return 0;
    return $urandom_range(1, LOOP ? 3 * n * PER : n * PER);
  endfunction

  task automatic load_one(input logic [11:0] w);
    logic can;
    can = (prog_m.size() < DEPTH);
    bus.load_valid = 1'b1;
    bus.load_word  = w;
    #1;
    check("load_ready", bus.load_ready, can);
    tick();
    bus.load_valid = 1'b0;
    if (can) prog_m.push_back(w);
    check("prog_len_after_load", prog_len, prog_m.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog_m.delete();
    check("prog_len_after_clear", prog_len, 0);
  endtask

  // Expected bus values for cycle k after the start edge.
  task automatic check_cycle(input int k, input int n, output int exp_pc);
    int j, ph, idx;
    logic [11:0] w;
    if (LOOP || k < 1 + n * PER) begin
      j   = (k - 1) / PER;
      ph  = (k - 1) % PER;
      idx = LOOP ? (j % n) : j;
      w   = prog_m[idx];
      exp_pc = idx;
      check("run_opcode", bus.cpu_opcode, (ph < HOLD) ? w[11:8] : 4'hF);
      check("run_data",   bus.cpu_data,   w[7:4]);
      check("run_addr",   bus.cpu_addr,   w[3:0]);
      check("run_we",     bus.cpu_we,     (ph < HOLD) && (w[11:8] == 4'h2));
      check("run_strobe", issue_strobe,   ph == 0);
      check("run_busy",   busy,           1);
      check("run_done",   done,           0);
      check("run_pc",     pc,             idx);
    end else begin
      exp_pc = n % DEPTH;
      check("done_opcode", bus.cpu_opcode, 4'hF);
      check("done_we",     bus.cpu_we,     0);
      check("done_strobe", issue_strobe,   0);
      check("done_busy",   busy,           0);
      check("done_done",   done,           1);
      check("done_pc",     pc,             exp_pc);
    end
  endtask

  // Start a run (optionally with a same-cycle load) and follow it to DONE
  // or to the cycle after stop.
  task automatic run(input int stop_at_in, input bit with_load, input logic [11:0] lw);
    int n, stop_at, pc_seen;
    bit finished;
    if (with_load) begin
      bus.load_valid = 1'b1;
      bus.load_word  = lw;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.load_valid = 1'b0;
    if (with_load) prog_m.push_back(lw);
    n = count_issue();
    stop_at = stop_at_in;
    if (LOOP && stop_at == 0) stop_at = pick_stop(n);
    $display("run: len=%0d issues=%0d stop_at=%0d", prog_m.size(), n, stop_at);
    finished = 1'b0;
    pc_seen  = 0;
    for (int k = 1; k <= 300 && !finished; k++) begin
      if (stop_at != 0 && k == stop_at + 1) begin
        check("stop_opcode", bus.cpu_opcode, 4'hF);
        check("stop_we",     bus.cpu_we,     0);
        check("stop_busy",   busy,           0);
        check("stop_done",   done,           0);
        check("stop_strobe", issue_strobe,   0);
        check("stop_pc",     pc,             pc_seen);
        check("stop_len",    prog_len,       prog_m.size());
        finished = 1'b1;
      end else begin
        check_cycle(k, n, pc_seen);
        if (!LOOP && stop_at == 0 && k == 1 + n * PER) begin
          finished = 1'b1;
        end else begin
          if (k == stop_at) stop = 1'b1;
          tick();
          stop = 1'b0;
        end
      end
    end
    check("run_terminated", finished, 1);
  endtask

  initial begin
    int n, len, sa;
    logic [11:0] w;
    bus.load_valid = 1'b0;
    bus.load_word  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_opcode", bus.cpu_opcode, 4'hF);
    check("reset_data",   bus.cpu_data,   0);
    check("reset_addr",   bus.cpu_addr,   0);
    check("reset_we",     bus.cpu_we,     0);
    check("reset_strobe", issue_strobe,   0);
    check("reset_pc",     pc,             0);
    check("reset_len",    prog_len,       0);
    check("reset_busy",   busy,           0);
    check("reset_done",   done,           0);
    check("reset_ready",  bus.load_ready, 1);

    // Three-word program, full run.
    load_one(12'h312);
    load_one(12'h055);
    load_one(12'h203);
    run(0, 1'b0, 12'h000);
    check("len_after_run", prog_len, 3);

    // Stop during the second instruction's hold, then rerun from slot 0.
    run(6, 1'b0, 12'h000);
    run(0, 1'b0, 12'h000);

    // HALT in the middle: the word after it is never driven.
    do_clear();
    load_one(12'h012);
    load_one(12'hF00);
    load_one(12'h5A1);
    run(0, 1'b0, 12'h000);

    // Fill all slots; the 17th offer is refused.
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      w = 12'($urandom);
      if (w[11:8] == 4'hF) w[11:8] = 4'h2;
      load_one(w);
    end
    load_one(12'h123);
    check("full_len", prog_len, DEPTH);
    run(0, 1'b0, 12'h000);

    // clear + start together: clear wins, nothing issued.
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    prog_m.delete();
    for (int i = 0; i < 3; i++) begin
      check("clrstart_len",    prog_len,       0);
      check("clrstart_busy",   busy,           0);
      check("clrstart_done",   done,           0);
      check("clrstart_strobe", issue_strobe,   0);
      check("clrstart_opcode", bus.cpu_opcode, 4'hF);
      tick();
    end

    // load + start with an empty buffer runs the one-word program.
    run(0, 1'b1, 12'h2A7);

    // Asynchronous reset in the middle of a hold.
    do_clear();
    load_one(12'h2C4);
    load_one(12'h1B3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("areset_opcode", bus.cpu_opcode, 4'hF);
    check("areset_we",     bus.cpu_we,     0);
    check("areset_busy",   busy,           0);
    check("areset_pc",     pc,             0);
    check("areset_len",    prog_len,       0);
    check("areset_ready",  bus.load_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    prog_m.delete();

    // Randomized programs with random stops.
    for (int t = 0; t < 15; t++) begin
      do_clear();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        w = 12'($urandom);
        if ($urandom_range(0, 5) == 0) w[11:8] = 4'hF;
        else if (w[11:8] == 4'hF)      w[11:8] = 4'($urandom_range(0, 14));
        if (LOOP && i == 0 && w[11:8] == 4'hF) w[11:8] = 4'h2;
        load_one(w);
      end
      n  = count_issue();
      sa = ($urandom_range(0, 1) == 1) ? pick_stop(n) : 0;
      run(sa, 1'b0, 12'h000);
      if (sa != 0) run(0, 1'b0, 12'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
